// File: rtl/soc_audio_sample_reader.sv
// Avalon-MM read master that drains a ring of audio samples from memory port s2
// into a first-word-fall-through prefetch FIFO and streams them on valid/ready.
module soc_audio_sample_reader #(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4058,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              underrun,
    input  logic              clear_underrun,
    output logic              busy,
    output logic [1:0]        state_dbg
);
    // Stream handshake: a sample transfers on any edge where sample_valid && sample_ready.

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE_L   = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W:0]    FIFO_CAP = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t              state_q, state_d;
    logic                cs_q, p1_q;
    logic [ADDR_W-1:0]   addr_q, rd_ptr_q;
    logic                underrun_q;
    logic [31:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wp_q, rp_q;
    logic [CNT_W-1:0]    count_q;

    logic                do_restart, issue, land, pop, credit_ok, underrun_set;
    logic [1:0]          inflight;
    logic [ADDR_W-1:0]   rd_base, rd_next;
    logic [CNT_W-1:0]    count_base;

    // p1_q marks a read the memory sampled last edge; its data is on readdata now.
    assign land     = p1_q;
    assign inflight = {1'b0, cs_q} + {1'b0, p1_q};
    assign pop      = (count_q != '0) && sample_ready;

    always_comb begin
        do_restart   = (state_q == IDLE) && restart;
        rd_base      = do_restart ? '0 : rd_ptr_q;
        count_base   = do_restart ? '0 : count_q;
        credit_ok    = ({1'b0, count_base} + (CNT_W+1)'(inflight)) < FIFO_CAP;
        issue        = enable && (state_q != DRAIN) && ({1'b0, wr_ptr} < DEPTH_X)
                       && (rd_base != wr_ptr) && credit_ok;
        rd_next      = (rd_base == LAST_IDX) ? '0 : rd_base + ADDR_W'(1);
        underrun_set = (state_q == RUN) && sample_ready && (count_q == '0) && !land;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN:   if (inflight == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        state_dbg = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q       <= 1'b0;
            p1_q       <= 1'b0;
            addr_q     <= BASE_L;
            rd_ptr_q   <= '0;
            underrun_q <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
        end else begin
            cs_q       <= issue;
            p1_q       <= cs_q;
            if (issue) addr_q <= BASE_L + rd_base;
            rd_ptr_q   <= issue ? rd_next : rd_base;
            underrun_q <= underrun_set | (underrun_q & ~clear_underrun);
            if (do_restart) begin
                wp_q    <= '0;
                rp_q    <= '0;
                count_q <= '0;
            end else begin
                if (land) wp_q <= wp_q + PTR_W'(1);
                if (pop)  rp_q <= rp_q + PTR_W'(1);
                case ({land, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (land) fifo_mem[wp_q] <= mem_readdata;
    end

    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_writedata  = 32'h0;
    assign sample_valid   = (count_q != '0);
    assign sample_data    = (count_q != '0) ? fifo_mem[rp_q] : 32'h0;
    assign rd_ptr         = rd_ptr_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_soc_audio_sample_reader.sv
// Directed bench for soc_audio_sample_reader with a registered-read memory model
// and an expected-sample queue checked by an independent stream monitor.
module tb_soc_audio_sample_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, restart, sample_ready, clear_underrun;
    logic [11:0] wr_ptr;
    logic [11:0] mem_address;
    logic        mem_chipselect, mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic [11:0] rd_ptr;
    logic        underrun, busy;
    logic [1:0]  state_dbg;

    logic [31:0] mem [4096];
    logic [31:0] mem_rd;
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    soc_audio_sample_reader dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .wr_ptr(wr_ptr),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .rd_ptr(rd_ptr), .underrun(underrun),
        .clear_underrun(clear_underrun), .busy(busy), .state_dbg(state_dbg)
    );

    // Memory port s2: address sampled at an edge, data valid the following cycle.
    always @(posedge clk) if (mem_chipselect) mem_rd <= mem[mem_address];
    assign mem_readdata = mem_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Stream monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL stream_extra: got %0h expected no sample", sample_data);
            end else begin
                check("stream", sample_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    int          n_cs, n_seen, gaps;
    logic [11:0] seen [8];

    initial begin
        reset = 1'b1; enable = 1'b0; restart = 1'b0; sample_ready = 1'b0;
        clear_underrun = 1'b0; wr_ptr = 12'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 + 32'(i);
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33;

        // Reset state and basic fetch
        wr_ptr = 12'd3; enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", sample_data, 32'd0);
        check("rst_rdptr", 32'(rd_ptr), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();
        check("e1_cs", 32'(mem_chipselect), 32'd1);
        check("e1_addr", 32'(mem_address), 32'd0);
        step();
        check("e2_cs", 32'(mem_chipselect), 32'd1);
        check("e2_addr", 32'(mem_address), 32'd1);
        step();
        check("e3_cs", 32'(mem_chipselect), 32'd1);
        check("e3_addr", 32'(mem_address), 32'd2);
        check("e3_valid", 32'(sample_valid), 32'd1);
        check("e3_data", sample_data, 32'd11);
        step();
        check("e4_cs", 32'(mem_chipselect), 32'd0);
        check("e4_rdptr", 32'(rd_ptr), 32'd3);
        step();
        exp_q.push_back(32'd11); exp_q.push_back(32'd22); exp_q.push_back(32'd33);
        sample_ready = 1'b1;
        repeat (3) step();
        check("basic_drained_valid", 32'(sample_valid), 32'd0);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
        sample_ready = 1'b0;

        // Backpressure credit: only FIFO_DEPTH reads outstanding
        for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 + 32'(i);
        wr_ptr = 12'd100; enable = 1'b1;
        do_reset();
        n_cs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (mem_chipselect) n_cs++;
        end
        check("credit_reads", 32'(n_cs), 32'd4);
        check("credit_cs_low", 32'(mem_chipselect), 32'd0);
        for (int i = 0; i < 100; i++) exp_q.push_back(mem[i]);
        sample_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            if (!sample_valid) gaps++;
            step();
        end
        check("stream_gaps", 32'(gaps), 32'd0);
        check("credit_queue_empty", 32'(exp_q.size()), 32'd0);
        check("credit_rdptr", 32'(rd_ptr), 32'd100);

        // Wrap-around: restart from IDLE, stream to 4056, then wrap past DEPTH-1
        enable = 1'b0; sample_ready = 1'b0;
        for (int i = 0; i < 10 && busy; i++) step();
        check("stop_idle", 32'(busy), 32'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_rdptr", 32'(rd_ptr), 32'd0);
        for (int i = 0; i < 4056; i++) exp_q.push_back(mem[i]);
        wr_ptr = 12'd4056; enable = 1'b1; sample_ready = 1'b1;
        for (int i = 0; i < 4400 && (exp_q.size() != 0 || rd_ptr != 12'd4056); i++) step();
        check("prewrap_rdptr", 32'(rd_ptr), 32'd4056);
        check("prewrap_queue_empty", 32'(exp_q.size()), 32'd0);
        sample_ready = 1'b0;
        wr_ptr = 12'd2;
        n_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mem_chipselect && n_seen < 8) begin
                seen[n_seen] = mem_address;
                n_seen++;
            end
        end
        check("wrap_nreads", 32'(n_seen), 32'd4);
        check("wrap_addr0", 32'(seen[0]), 32'd4056);
        check("wrap_addr1", 32'(seen[1]), 32'd4057);
        check("wrap_addr2", 32'(seen[2]), 32'd0);
        check("wrap_addr3", 32'(seen[3]), 32'd1);
        check("wrap_rdptr", 32'(rd_ptr), 32'd2);
        exp_q.push_back(mem[4056]); exp_q.push_back(mem[4057]);
        exp_q.push_back(mem[0]);    exp_q.push_back(mem[1]);
        sample_ready = 1'b1;
        repeat (6) step();
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
        sample_ready = 1'b0;
        wr_ptr = 12'd4058;
        n_cs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_chipselect) n_cs++;
        end
        check("oob_wrptr_reads", 32'(n_cs), 32'd0);
        check("oob_wrptr_rdptr", 32'(rd_ptr), 32'd2);

        // Underrun set, clear collision, clear
        wr_ptr = 12'd1; enable = 1'b1;
        do_reset();
        for (int i = 0; i < 10 && !sample_valid; i++) step();
        check("ur_first_valid", 32'(sample_valid), 32'd1);
        exp_q.push_back(mem[0]);
        sample_ready = 1'b1;
        step();
        check("ur_not_yet", 32'(underrun), 32'd0);
        step();
        check("ur_set", 32'(underrun), 32'd1);
        check("ur_fifo_empty", 32'(sample_valid), 32'd0);
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        check("ur_set_wins", 32'(underrun), 32'd1);
        sample_ready = 1'b0; clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        check("ur_cleared", 32'(underrun), 32'd0);
        enable = 1'b0;
        repeat (3) step();
        sample_ready = 1'b1;
        repeat (3) step();
        check("ur_idle_busy", 32'(busy), 32'd0);
        check("ur_not_in_idle", 32'(underrun), 32'd0);
        sample_ready = 1'b0;

        // Stop with two reads in flight, drain, stream in IDLE, restart
        wr_ptr = 12'd100; enable = 1'b1;
        do_reset();
        step();
        step();
        enable = 1'b0;
        step();
        check("drain_busy1", 32'(busy), 32'd1);
        check("drain_cs", 32'(mem_chipselect), 32'd0);
        step();
        check("drain_busy2", 32'(busy), 32'd1);
        step();
        check("drain_idle", 32'(busy), 32'd0);
        check("drain_valid", 32'(sample_valid), 32'd1);
        check("drain_rdptr", 32'(rd_ptr), 32'd2);
        exp_q.push_back(mem[0]);
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        check("idle_second_data", sample_data, mem[1]);
        check("idle_queue_empty", 32'(exp_q.size()), 32'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart2_rdptr", 32'(rd_ptr), 32'd0);
        check("restart2_valid", 32'(sample_valid), 32'd0);

        // Asynchronous reset mid-stream
        wr_ptr = 12'd1; enable = 1'b1; sample_ready = 1'b1;
        do_reset();
        exp_q.push_back(mem[0]);
        repeat (6) step();
        check("ar_underrun_pre", 32'(underrun), 32'd1);
        check("ar_queue_empty", 32'(exp_q.size()), 32'd0);
        sample_ready = 1'b0; wr_ptr = 12'd50;
        repeat (6) step();
        check("ar_valid_pre", 32'(sample_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(sample_valid), 32'd0);
        check("ar_cs", 32'(mem_chipselect), 32'd0);
        check("ar_rdptr", 32'(rd_ptr), 32'd0);
        check("ar_underrun", 32'(underrun), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        step();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
